lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the execute stage. Takes the ALU result (effective address or pass-through value), the store operand and the destination register, performs at most one memory transaction over a simple request/response data bus, and presents a write-back packet to the next stage. Handles byte/halfword/word sizing, write-mask generation, load sign/zero extension and misalignment detection. All handshakes use valid/ready.

## Interface
- ADDR_W, 32, address width; bus address is always word-aligned.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute stage result valid
- in_ready  out  1  LSU can accept a new instruction
- mem_ren  in  1  instruction is a load
- mem_wen  in  1  instruction is a store
- mem_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- alu_result  in  32  effective address, or write-back value for non-memory ops
- rs2_data  in  32  store data
- rd  in  5  destination register
- reg_wen  in  1  instruction writes rd
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}
- req_wen  out  1  1 = write, 0 = read
- req_wdata  out  32  lane-replicated store data
- req_wmask  out  4  byte enables (0 for reads)
- rsp_valid  in  1  bus response valid (one-cycle pulse, no backpressure)
- rsp_rdata  in  32  read data word
- rsp_err  in  1  bus error, qualified by rsp_valid
- out_valid  out  1  write-back packet valid
- out_ready  in  1  write-back stage accepts packet
- out_data  out  32  write-back value
- out_rd  out  5  destination register
- out_reg_wen  out  1  write enable for rd
- out_err  out  1  misaligned access, illegal op or bus error

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. in_ready = (state == IDLE).
- IDLE: on in_valid, capture all inputs.
  - mem_ren = mem_wen = 0: out_data = alu_result, go to DONE.
  - mem_ren & mem_wen both 1, or illegal mem_op for the access type: out_err = 1, go to DONE.
  - Misaligned (H with addr[0] = 1; W with addr[1:0] != 0): out_err = 1, go to DONE, no bus activity.
  - Otherwise go to REQ.
- REQ: req_valid = 1, with addr/wen/wdata/wmask held stable until req_ready. On handshake go to WAIT. rsp_valid is ignored in REQ.
- WAIT: on rsp_valid, go to DONE. Loads: out_data = extracted lane (rdata >> 8*addr[1:0]), sign-extended for B/H, zero-extended for BU/HU. Stores: out_data = 0. rsp_err = 1 sets out_err.
- Store encoding:
  - SB: wmask = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wmask = 4'b0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: wmask = 4'b1111, wdata = rs2.
- DONE: out_valid = 1, all out_* held until out_ready, then go to IDLE.
- out_reg_wen = reg_wen & ~mem_wen & ~out_err. Errors and stores never write rd.

## Timing
- Reset (async assert) forces:
  - state = IDLE, in_ready = 1.
  - req_valid = out_valid = out_err = out_reg_wen = 0.
  - out_data = out_rd = req_addr = req_wdata = req_wmask = req_wen = 0.
- Reset mid-transaction drops req_valid/out_valid immediately and abandons the access. A late rsp_valid arriving in IDLE is ignored.
- Accept at cycle N:
  - Non-memory or error: out_valid at N+1.
  - Memory access: req_valid at N+1. With req_ready at N+1, WAIT at N+2, and rsp_valid at N+k gives out_valid at N+k+1. Minimum load/store latency is 3 cycles.
- No new instruction is accepted until the DONE handshake completes (single outstanding access, no bypass from DONE to accept).
- req_ready held low: stay in REQ indefinitely with stable outputs. out_ready held low: stay in DONE with stable packet.

## Test plan
- Non-memory pass-through: alu_result=0x12345678, rd=5, reg_wen=1 -> out_valid next cycle, out_data=0x12345678, out_rd=5, out_reg_wen=1, req_valid never asserted.
- LB at 0x80000003, rsp_rdata=0x80FF0011 -> req_addr=0x80000000, wmask=0, out_data=0xFFFFFF80. Same access as LBU -> out_data=0x00000080.
- SH at 0x80000006, rs2=0xAABBCCDD -> req_addr=0x80000004, wmask=4'b1100, wdata=0xCCDDCCDD, req_wen=1, out_reg_wen=0.
- LW at 0x80000002 -> out_err=1 one cycle after accept, no req_valid, out_reg_wen=0.
- req_ready low 3 cycles then high, rsp_valid 2 cycles later, out_ready low 2 cycles -> req and out fields stable throughout, exactly one bus request, next in_ready only after out handshake.
- Assert rst while in WAIT -> req_valid/out_valid 0 immediately, in_ready=1 after release, subsequent stray rsp_valid produces no out_valid.

Source files
------------

// File: rtl/lsu.sv
// lsu: load/store unit between execute and write-back. Accepts one instruction at a time,
// performs at most one word-aligned bus transaction, and presents a write-back packet.
module lsu #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic              i_mem_ren,
   input  logic              i_mem_wen,
   input  logic [2:0]        i_mem_op,
   input  logic [31:0]       i_alu_result,
   input  logic [31:0]       i_rs2_data,
   input  logic [4:0]        i_rd,
   input  logic              i_reg_wen,
   output logic              o_req_valid,
   input  logic              i_req_ready,
   output logic [ADDR_W-1:0] o_req_addr,
   output logic              o_req_wen,
   output logic [31:0]       o_req_wdata,
   output logic [3:0]        o_req_wmask,
   input  logic              i_rsp_valid,
   input  logic [31:0]       i_rsp_rdata,
   input  logic              i_rsp_err,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [31:0]       o_out_data,
   output logic [4:0]        o_out_rd,
   output logic              o_out_reg_wen,
   output logic              o_out_err
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [2:0]        r_op;
   logic [1:0]        r_addr_lo;
   logic              r_is_store;
   logic              r_reg_wen;
   logic [4:0]        r_rd;
   logic [31:0]       r_out_data;
   logic              r_out_err;
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_req_wen;
   logic [31:0]       r_req_wdata;
   logic [3:0]        r_req_wmask;

   logic              w_accept;
   logic              w_is_mem;
   logic              w_op_legal;
   logic              w_misal;
   logic              w_acc_err;
   logic [3:0]        w_st_mask;
   logic [31:0]       w_st_wdata;
   logic [31:0]       w_lane;
   logic [31:0]       w_ld_data;

   // Classify the instruction offered by execute: memory or not, legal, aligned
   always_comb begin
      w_accept = i_in_valid & (r_state == StIdle);
      w_is_mem = i_mem_ren | i_mem_wen;
      case (i_mem_op)
         3'b000, 3'b001, 3'b010: w_op_legal = 1'b1;
         // Unsigned forms only make sense for loads
         3'b100, 3'b101:         w_op_legal = ~i_mem_wen;
         default:                w_op_legal = 1'b0;
      endcase
      w_misal = ((i_mem_op[1:0] == 2'b01) & i_alu_result[0])
              | ((i_mem_op[1:0] == 2'b10) & (i_alu_result[1:0] != 2'b00));
      w_acc_err = (i_mem_ren & i_mem_wen) | ~w_op_legal | w_misal;
   end

   // Store byte enables and lane-replicated write data
   always_comb begin
      w_st_mask  = 4'b1111;
      w_st_wdata = i_rs2_data;
      case (i_mem_op[1:0])
         2'b00: begin
            w_st_mask  = 4'b0001 << i_alu_result[1:0];
            w_st_wdata = {4{i_rs2_data[7:0]}};
         end
         2'b01: begin
            w_st_mask  = 4'b0011 << i_alu_result[1:0];
            w_st_wdata = {2{i_rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane extraction with sign/zero extension
   always_comb begin
      w_lane = i_rsp_rdata >> {r_addr_lo, 3'b000};
      case (r_op)
         3'b000:  w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b100:  w_ld_data = {24'd0, w_lane[7:0]};
         3'b101:  w_ld_data = {16'd0, w_lane[15:0]};
         default: w_ld_data = w_lane;
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      o_in_ready  = 1'b0;
      o_req_valid = 1'b0;
      o_out_valid = 1'b0;
      case (r_state)
         StIdle: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               w_state_nxt = (w_is_mem && !w_acc_err) ? StReq : StDone;
            end
         end
         StReq: begin
            o_req_valid = 1'b1;
            if (i_req_ready) w_state_nxt = StWait;
         end
         StWait: begin
            if (i_rsp_valid) w_state_nxt = StDone;
         end
         StDone: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Capture the instruction on accept and the bus response in WAIT
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op        <= 3'd0;
         r_addr_lo   <= 2'd0;
         r_is_store  <= 1'b0;
         r_reg_wen   <= 1'b0;
         r_rd        <= 5'd0;
         r_out_data  <= 32'd0;
         r_out_err   <= 1'b0;
         r_req_addr  <= '0;
         r_req_wen   <= 1'b0;
         r_req_wdata <= 32'd0;
         r_req_wmask <= 4'd0;
      end else if (w_accept) begin
         r_op       <= i_mem_op;
         r_addr_lo  <= i_alu_result[1:0];
         r_is_store <= i_mem_wen;
         r_reg_wen  <= i_reg_wen;
         r_rd       <= i_rd;
         if (!w_is_mem) begin
            r_out_data <= i_alu_result;
            r_out_err  <= 1'b0;
         end else if (w_acc_err) begin
            r_out_data <= 32'd0;
            r_out_err  <= 1'b1;
         end else begin
            r_out_data  <= 32'd0;
            r_out_err   <= 1'b0;
            r_req_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
            r_req_wen   <= i_mem_wen;
            r_req_wdata <= i_mem_wen ? w_st_wdata : 32'd0;
            r_req_wmask <= i_mem_wen ? w_st_mask : 4'd0;
         end
      end else if (r_state == StWait && i_rsp_valid) begin
         r_out_data <= r_is_store ? 32'd0 : w_ld_data;
         r_out_err  <= i_rsp_err;
      end
   end

   // Packet and request fields come straight from registers, so they hold while stalled
   always_comb begin
      o_req_addr    = r_req_addr;
      o_req_wen     = r_req_wen;
      o_req_wdata   = r_req_wdata;
      o_req_wmask   = r_req_wmask;
      o_out_data    = r_out_data;
      o_out_rd      = r_rd;
      o_out_err     = r_out_err;
      o_out_reg_wen = r_reg_wen & ~r_is_store & ~r_out_err;
   end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed checks of lsu against a byte-level reference model.
`timescale 1ns/1ps
module tb_lsu;

   localparam int unsigned ADDR_W = 32;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_in_valid;
   logic              o_in_ready;
   logic              i_mem_ren;
   logic              i_mem_wen;
   logic [2:0]        i_mem_op;
   logic [31:0]       i_alu_result;
   logic [31:0]       i_rs2_data;
   logic [4:0]        i_rd;
   logic              i_reg_wen;
   logic              o_req_valid;
   logic              i_req_ready;
   logic [ADDR_W-1:0] o_req_addr;
   logic              o_req_wen;
   logic [31:0]       o_req_wdata;
   logic [3:0]        o_req_wmask;
   logic              i_rsp_valid;
   logic [31:0]       i_rsp_rdata;
   logic              i_rsp_err;
   logic              o_out_valid;
   logic              i_out_ready;
   logic [31:0]       o_out_data;
   logic [4:0]        o_out_rd;
   logic              o_out_reg_wen;
   logic              o_out_err;

   int n_checks = 0;
   int n_errors = 0;

   lsu #(.ADDR_W(ADDR_W)) u_dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_in_valid    (i_in_valid),
      .o_in_ready    (o_in_ready),
      .i_mem_ren     (i_mem_ren),
      .i_mem_wen     (i_mem_wen),
      .i_mem_op      (i_mem_op),
      .i_alu_result  (i_alu_result),
      .i_rs2_data    (i_rs2_data),
      .i_rd          (i_rd),
      .i_reg_wen     (i_reg_wen),
      .o_req_valid   (o_req_valid),
      .i_req_ready   (i_req_ready),
      .o_req_addr    (o_req_addr),
      .o_req_wen     (o_req_wen),
      .o_req_wdata   (o_req_wdata),
      .o_req_wmask   (o_req_wmask),
      .i_rsp_valid   (i_rsp_valid),
      .i_rsp_rdata   (i_rsp_rdata),
      .i_rsp_err     (i_rsp_err),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (i_out_ready),
      .o_out_data    (o_out_data),
      .o_out_rd      (o_out_rd),
      .o_out_reg_wen (o_out_reg_wen),
      .o_out_err     (o_out_err)
   );

   always #5 i_clk = ~i_clk;

   // Reference: access size in bytes, alignment by modulo, lanes by byte arithmetic
   task automatic model(
      input  logic ren, input logic wen, input logic [2:0] op, input logic [31:0] alu,
      input  logic [31:0] rs2, input logic [31:0] rdata, input logic berr, input logic rwen,
      output logic mem, output logic err, output logic [31:0] data, output logic regwen,
      output logic [31:0] addr, output logic [3:0] mask, output logic [31:0] wdata);
      int     size;
      int     off;
      longint v;
      longint lim;
      bit     legal;
      mem = 0; err = 0; data = 0; addr = 0; mask = 0; wdata = 0;
      off = int'(alu % 4);
      case (op)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      legal = (size != 0) && !(wen && op >= 3'd4);
      if (!ren && !wen) begin
         data = alu;
      end else if ((ren && wen) || !legal) begin
         err = 1;
      end else if ((off % size) != 0) begin
         err = 1;
      end else begin
         mem  = 1;
         addr = alu - 32'(off);
         if (wen) begin
            for (int b = 0; b < size; b++) mask[off + b] = 1'b1;
            for (int b = 0; b < 4; b++) wdata[8*b +: 8] = rs2[8*(b % size) +: 8];
         end else begin
            lim = longint'(1) << (8 * size);
            v = (longint'(rdata) >> (8 * off)) % lim;
            if (op < 3'd4 && v >= lim / 2) v = v - lim;
            data = v[31:0];
         end
         err = berr;
      end
      regwen = rwen && !wen && !err;
   endtask

   // Drive one instruction through accept, bus and write-back; report what was observed
   task automatic run_txn(
      input  logic ren, input logic wen, input logic [2:0] op, input logic [31:0] alu,
      input  logic [31:0] rs2, input logic [4:0] rd, input logic rwen,
      input  int req_dly, input int rsp_dly, input int out_dly,
      input  logic [31:0] rdata, input logic berr, input bit noise,
      output int n_req, output logic [31:0] q_addr, output logic q_wen,
      output logic [31:0] q_wdata, output logic [3:0] q_mask,
      output logic [31:0] p_data, output logic [4:0] p_rd, output logic p_rwen,
      output logic p_err, output int lat, output bit unstable, output bit busy_ready,
      output bit timeout, output bit idle_after);
      int t;
      int req_seen;
      int out_seen;
      int rsp_cnt;
      bit waiting;
      bit done;
      n_req = 0; q_addr = 0; q_wen = 0; q_wdata = 0; q_mask = 0;
      p_data = 0; p_rd = 0; p_rwen = 0; p_err = 0; lat = -1;
      unstable = 0; busy_ready = 0; timeout = 0; idle_after = 0;
      t = 0;
      while (!o_in_ready && t < 50) begin
         @(negedge i_clk);
         t++;
      end
      if (!o_in_ready) timeout = 1;
      i_in_valid = 1; i_mem_ren = ren; i_mem_wen = wen; i_mem_op = op;
      i_alu_result = alu; i_rs2_data = rs2; i_rd = rd; i_reg_wen = rwen;
      @(negedge i_clk);
      // Scramble the inputs after accept so only captured values can reach the outputs
      i_in_valid = 0; i_mem_ren = 1'($urandom); i_mem_wen = 1'($urandom);
      i_mem_op = 3'($urandom); i_alu_result = $urandom; i_rs2_data = $urandom;
      i_rd = 5'($urandom); i_reg_wen = 1'($urandom);
      t = 1; req_seen = 0; out_seen = 0; rsp_cnt = 0; waiting = 0; done = 0;
      while (!done && t <= 100) begin
         i_rsp_valid = 0; i_req_ready = 0; i_out_ready = 0;
         if (o_in_ready) busy_ready = 1;
         if (o_req_valid) begin
            if (req_seen == 0) begin
               q_addr = o_req_addr; q_wen = o_req_wen; q_wdata = o_req_wdata;
               q_mask = o_req_wmask;
            end else if ({o_req_addr, o_req_wen, o_req_wdata, o_req_wmask}
                         !== {q_addr, q_wen, q_wdata, q_mask}) begin
               unstable = 1;
            end
            req_seen++;
            if (req_seen > req_dly) begin
               i_req_ready = 1; n_req++; waiting = 1; rsp_cnt = 0;
            end else if (noise) begin
               i_rsp_valid = 1; i_rsp_rdata = $urandom; i_rsp_err = 1'($urandom);
            end
         end else if (waiting) begin
            rsp_cnt++;
            if (rsp_cnt > rsp_dly) begin
               i_rsp_valid = 1; i_rsp_rdata = rdata; i_rsp_err = berr; waiting = 0;
            end
         end
         if (o_out_valid) begin
            if (out_seen == 0) begin
               lat = t; p_data = o_out_data; p_rd = o_out_rd; p_rwen = o_out_reg_wen;
               p_err = o_out_err;
            end else if ({o_out_data, o_out_rd, o_out_reg_wen, o_out_err}
                         !== {p_data, p_rd, p_rwen, p_err}) begin
               unstable = 1;
            end
            out_seen++;
            if (out_seen > out_dly) begin
               i_out_ready = 1; done = 1;
            end
         end
         @(negedge i_clk);
         t++;
      end
      if (!done) timeout = 1;
      i_out_ready = 0; i_req_ready = 0; i_rsp_valid = 0;
      idle_after = o_in_ready;
   endtask

   task automatic test_reset();
      i_rst = 1; i_in_valid = 0; i_mem_ren = 0; i_mem_wen = 0; i_mem_op = 0;
      i_alu_result = 0; i_rs2_data = 0; i_rd = 0; i_reg_wen = 0; i_req_ready = 0;
      i_rsp_valid = 0; i_rsp_rdata = 0; i_rsp_err = 0; i_out_ready = 0;
      repeat (3) @(negedge i_clk);
      i_rst = 0;
      @(negedge i_clk);
      n_checks++;
      if (o_in_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready);
      end
      n_checks++;
      if ({o_req_valid, o_out_valid, o_out_err, o_out_reg_wen, o_req_wen} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_flags got=%b%b%b%b%b exp=00000", o_req_valid, o_out_valid,
                  o_out_err, o_out_reg_wen, o_req_wen);
      end
      n_checks++;
      if ({o_out_data, o_out_rd} !== 37'd0) begin
         n_errors++; $display("FAIL reset_out got=%h/%0d exp=0/0", o_out_data, o_out_rd);
      end
      n_checks++;
      if ({o_req_addr, o_req_wdata, o_req_wmask} !== 68'd0) begin
         n_errors++;
         $display("FAIL reset_req got=%h/%h/%b exp=0/0/0", o_req_addr, o_req_wdata, o_req_wmask);
      end
   endtask

   task automatic test_passthrough();
      int n_req; int lat; logic [31:0] qa; logic qw; logic [31:0] qd; logic [3:0] qm;
      logic [31:0] pd; logic [4:0] pr; logic pw; logic pe; bit us; bit br; bit to; bit ia;
      run_txn(0, 0, 3'b000, 32'h1234_5678, $urandom, 5'd5, 1, 0, 0, 0, 0, 0, 0,
              n_req, qa, qw, qd, qm, pd, pr, pw, pe, lat, us, br, to, ia);
      n_checks++;
      if (lat !== 1 || n_req !== 0) begin
         n_errors++; $display("FAIL pass_timing got lat=%0d req=%0d exp lat=1 req=0", lat, n_req);
      end
      n_checks++;
      if ({pd, pr, pw, pe} !== {32'h1234_5678, 5'd5, 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL pass_packet got=%h/%0d/%b/%b exp=12345678/5/1/0", pd, pr, pw, pe);
      end
   endtask

   task automatic test_load_ext();
      int n_req; int lat; logic [31:0] qa; logic qw; logic [31:0] qd; logic [3:0] qm;
      logic [31:0] pd; logic [4:0] pr; logic pw; logic pe; bit us; bit br; bit to; bit ia;
      run_txn(1, 0, 3'b000, 32'h8000_0003, 0, 5'd7, 1, 0, 0, 0, 32'h80FF_0011, 0, 0,
              n_req, qa, qw, qd, qm, pd, pr, pw, pe, lat, us, br, to, ia);
      n_checks++;
      if ({qa, qw, qm} !== {32'h8000_0000, 1'b0, 4'b0000} || n_req !== 1) begin
         n_errors++; $display("FAIL lb_req got=%h/%b/%b n=%0d exp=80000000/0/0000 n=1",
                              qa, qw, qm, n_req);
      end
      n_checks++;
      if (pd !== 32'hFFFF_FF80 || lat !== 3 || pw !== 1'b1) begin
         n_errors++;
         $display("FAIL lb_data got=%h lat=%0d wen=%b exp=ffffff80 lat=3 wen=1", pd, lat, pw);
      end
      run_txn(1, 0, 3'b100, 32'h8000_0003, 0, 5'd7, 1, 0, 0, 0, 32'h80FF_0011, 0, 0,
              n_req, qa, qw, qd, qm, pd, pr, pw, pe, lat, us, br, to, ia);
      n_checks++;
      if (pd !== 32'h0000_0080) begin
         n_errors++; $display("FAIL lbu_data got=%h exp=00000080", pd);
      end
   endtask

   task automatic test_store_half();
      int n_req; int lat; logic [31:0] qa; logic qw; logic [31:0] qd; logic [3:0] qm;
      logic [31:0] pd; logic [4:0] pr; logic pw; logic pe; bit us; bit br; bit to; bit ia;
      run_txn(0, 1, 3'b001, 32'h8000_0006, 32'hAABB_CCDD, 5'd9, 1, 0, 0, 0, 0, 0, 0,
              n_req, qa, qw, qd, qm, pd, pr, pw, pe, lat, us, br, to, ia);
      n_checks++;
      if ({qa, qw, qd, qm} !== {32'h8000_0004, 1'b1, 32'hCCDD_CCDD, 4'b1100}) begin
         n_errors++; $display("FAIL sh_req got=%h/%b/%h/%b exp=80000004/1/ccddccdd/1100",
                              qa, qw, qd, qm);
      end
      n_checks++;
      if (pw !== 1'b0 || pe !== 1'b0 || pd !== 32'd0) begin
         n_errors++; $display("FAIL sh_packet got wen=%b err=%b data=%h exp 0/0/0", pw, pe, pd);
      end
   endtask

   task automatic test_misaligned();
      int n_req; int lat; logic [31:0] qa; logic qw; logic [31:0] qd; logic [3:0] qm;
      logic [31:0] pd; logic [4:0] pr; logic pw; logic pe; bit us; bit br; bit to; bit ia;
      run_txn(1, 0, 3'b010, 32'h8000_0002, 0, 5'd4, 1, 0, 0, 0, $urandom, 0, 0,
              n_req, qa, qw, qd, qm, pd, pr, pw, pe, lat, us, br, to, ia);
      n_checks++;
      if (pe !== 1'b1 || pw !== 1'b0 || lat !== 1 || n_req !== 0) begin
         n_errors++; $display("FAIL lw_misaligned got err=%b wen=%b lat=%0d req=%0d exp 1/0/1/0",
                              pe, pw, lat, n_req);
      end
   endtask

   task automatic test_stall();
      int n_req; int lat; logic [31:0] qa; logic qw; logic [31:0] qd; logic [3:0] qm;
      logic [31:0] pd; logic [4:0] pr; logic pw; logic pe; bit us; bit br; bit to; bit ia;
      run_txn(1, 0, 3'b010, 32'h0000_1008, 0, 5'd12, 1, 3, 1, 2, 32'hDEAD_BEEF, 0, 1,
              n_req, qa, qw, qd, qm, pd, pr, pw, pe, lat, us, br, to, ia);
      n_checks++;
      if (us || n_req !== 1 || to) begin
         n_errors++; $display("FAIL stall_bus got unstable=%0b req=%0d timeout=%0b exp 0/1/0",
                              us, n_req, to);
      end
      n_checks++;
      if (lat !== 7 || pd !== 32'hDEAD_BEEF || qa !== 32'h0000_1008) begin
         n_errors++; $display("FAIL stall_result got lat=%0d data=%h addr=%h exp 7/deadbeef/1008",
                              lat, pd, qa);
      end
      n_checks++;
      if (br || !ia) begin
         n_errors++; $display("FAIL stall_in_ready got busy=%0b after=%0b exp 0/1", br, ia);
      end
   endtask

   task automatic test_random();
      int n_req; int lat; logic [31:0] qa; logic qw; logic [31:0] qd; logic [3:0] qm;
      logic [31:0] pd; logic [4:0] pr; logic pw; logic pe; bit us; bit br; bit to; bit ia;
      logic ren; logic wen; logic [2:0] op; logic [31:0] alu; logic [31:0] rs2;
      logic [31:0] rdata; logic berr; logic [4:0] rd; logic rwen;
      int kind; int d_req; int d_rsp; int d_out; int exp_lat;
      logic e_mem; logic e_err; logic [31:0] e_data; logic e_rwen; logic [31:0] e_addr;
      logic [3:0] e_mask; logic [31:0] e_wdata;
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 9);
         ren = (kind >= 2 && kind <= 5) || kind == 9;
         wen = (kind >= 6);
         op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) op = (op % 3);
         if (ren && !wen && $urandom_range(0, 2) == 0) op = 3'd4 + 3'($urandom_range(0, 1));
         alu = $urandom; rs2 = $urandom; rdata = $urandom; rd = 5'($urandom);
         rwen = 1'($urandom); berr = ($urandom_range(0, 7) == 0);
         d_req = $urandom_range(0, 3); d_rsp = $urandom_range(0, 3); d_out = $urandom_range(0, 3);
         model(ren, wen, op, alu, rs2, rdata, berr, rwen,
               e_mem, e_err, e_data, e_rwen, e_addr, e_mask, e_wdata);
         run_txn(ren, wen, op, alu, rs2, rd, rwen, d_req, d_rsp, d_out, rdata, berr,
                 bit'($urandom_range(0, 1)),
                 n_req, qa, qw, qd, qm, pd, pr, pw, pe, lat, us, br, to, ia);
         exp_lat = e_mem ? 3 + d_req + d_rsp : 1;
         n_checks++;
         if (n_req !== int'(e_mem) || lat !== exp_lat || to) begin
            n_errors++; $display("FAIL rnd%0d_flow got req=%0d lat=%0d to=%0b exp req=%0d lat=%0d",
                                 i, n_req, lat, to, e_mem, exp_lat);
         end
         n_checks++;
         if ({pe, pw, pr} !== {e_err, e_rwen, rd}) begin
            n_errors++; $display("FAIL rnd%0d_ctl got err=%b wen=%b rd=%0d exp %b/%b/%0d",
                                 i, pe, pw, pr, e_err, e_rwen, rd);
         end
         if (!e_err) begin
            n_checks++;
            if (pd !== e_data) begin
               n_errors++; $display("FAIL rnd%0d_data op=%0d ren=%b addr=%h got=%h exp=%h",
                                    i, op, ren, alu, pd, e_data);
            end
         end
         if (e_mem) begin
            n_checks++;
            if ({qa, qw, qm} !== {e_addr, wen, e_mask} || (wen && qd !== e_wdata)) begin
               n_errors++; $display("FAIL rnd%0d_req got=%h/%b/%b/%h exp=%h/%b/%b/%h",
                                    i, qa, qw, qm, qd, e_addr, wen, e_mask, e_wdata);
            end
         end
         n_checks++;
         if (us || br || !ia) begin
            n_errors++; $display("FAIL rnd%0d_hs got unstable=%0b busy=%0b after=%0b exp 0/0/1",
                                 i, us, br, ia);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic pre;
      bit   seen;
      for (int s = 0; s < 3; s++) begin
         i_in_valid = 1; i_mem_ren = (s != 2); i_mem_wen = 0; i_mem_op = 3'b010;
         i_alu_result = 32'h8000_0010; i_rd = 5'd3; i_reg_wen = 1; i_req_ready = 0;
         i_out_ready = 0; i_rsp_valid = 0;
         @(negedge i_clk);
         i_in_valid = 0;
         if (s == 1) begin
            i_req_ready = 1;
            @(negedge i_clk);
            i_req_ready = 0;
         end
         case (s)
            0:       pre = o_req_valid;
            1:       pre = !o_in_ready && !o_req_valid && !o_out_valid;
            default: pre = o_out_valid;
         endcase
         n_checks++;
         if (pre !== 1'b1) begin
            n_errors++; $display("FAIL rstmid%0d_pre got=%b exp=1", s, pre);
         end
         #2 i_rst = 1;
         #1;
         n_checks++;
         if ({o_req_valid, o_out_valid, o_in_ready} !== 3'b001) begin
            n_errors++; $display("FAIL rstmid%0d_drop got req/out/rdy=%b%b%b exp=001",
                                 s, o_req_valid, o_out_valid, o_in_ready);
         end
         @(negedge i_clk);
         i_rst = 0;
         i_rsp_valid = 1; i_rsp_rdata = $urandom; i_rsp_err = 0;
         @(negedge i_clk);
         i_rsp_valid = 0;
         seen = 0;
         for (int c = 0; c < 4; c++) begin
            if (o_out_valid || o_req_valid || !o_in_ready) seen = 1;
            @(negedge i_clk);
         end
         n_checks++;
         if (seen) begin
            n_errors++; $display("FAIL rstmid%0d_stray got activity=1 exp=0", s);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_passthrough();
      test_load_ext();
      test_store_half();
      test_misaligned();
      test_stall();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
